// File: rtl/sn7474_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sn7474_ctrl_pkg
// Purpose  : Shared command, state and requester encodings for sn7474_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
package sn7474_ctrl_pkg;

    localparam logic [1:0] CMD_LOAD   = 2'b00;
    localparam logic [1:0] CMD_PRESET = 2'b01;
    localparam logic [1:0] CMD_CLEAR  = 2'b10;
    localparam logic [1:0] CMD_READ   = 2'b11;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_HIGH   = 3'd2,
        ST_LOW    = 3'd3,
        ST_PULSE  = 3'd4,
        ST_SETTLE = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    // Q the flip-flop should show once a command has completed (READ unused).
    function automatic logic expected_q(input logic [1:0] cmd, input logic data);
        case (cmd)
            CMD_LOAD:   return data;
            CMD_PRESET: return 1'b1;
            default:    return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/sn7474_ctrl_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-input round-robin arbiter; last-grant register starts at B.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    input  logic update,
    output logic grant_a,
    output logic grant_b
);
    import sn7474_ctrl_pkg::*;

    logic r_last;

    // On a tie the requester that did not win last time gets the grant.
    assign grant_a = en & req_a & (~req_b | (r_last == REQ_B));
    assign grant_b = en & req_b & (~req_a | (r_last == REQ_A));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= REQ_B;
        end else if (update) begin
            r_last <= grant_b ? REQ_B : REQ_A;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sn7474_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sn7474_ctrl
// Purpose  : Pin-level sequencer for one sn7474 dual D flip-flop with
//            round-robin command arbitration and a response self-check.
//            Optional macro SN7474_CTRL_STATS_EN builds the stat counters.
// Revision : 1.0 - initial release
// ============================================================================
module sn7474_ctrl #(
    parameter int T_SETUP  = 3,
    parameter int T_HIGH   = 6,
    parameter int T_LOW    = 3,
    parameter int T_PULSE  = 1,
    parameter int T_SETTLE = 1,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [1:0]  a_cmd,
    input  logic        a_chan,
    input  logic        a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [1:0]  b_cmd,
    input  logic        b_chan,
    input  logic        b_data,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic        rsp_q,
    output logic        rsp_err,
    output logic        P1,
    output logic        P2,
    output logic        P3,
    output logic        P4,
    input  logic        P5,
    input  logic        P6,
    input  logic        P8,
    input  logic        P9,
    output logic        P10,
    output logic        P11,
    output logic        P12,
    output logic        P13,
    output logic [15:0] stat_cmds,
    output logic [15:0] stat_errs
);
    import sn7474_ctrl_pkg::*;

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_cmd;
    logic             r_chan, r_data, r_id;
    logic [1:0]       r_clk, r_d, r_pre_n, r_clr_n;
    logic             r_rsp_valid, r_rsp_id, r_rsp_q, r_rsp_err;

    logic             w_grant_a, w_grant_b, w_accept, w_cnt_done;
    logic [1:0]       w_cmd_in, w_cmd_sel, w_chan_oh;
    logic             w_chan_in, w_data_in, w_chan_sel;
    logic             w_q, w_qb, w_err;

    function automatic logic [CNT_W-1:0] phase_init(input state_t s);
        case (s)
            ST_SETUP:  return CNT_W'(T_SETUP - 1);
            ST_HIGH:   return CNT_W'(T_HIGH - 1);
            ST_LOW:    return CNT_W'(T_LOW - 1);
            ST_PULSE:  return CNT_W'(T_PULSE - 1);
            ST_SETTLE: return CNT_W'(T_SETTLE - 1);
            default:   return '0;
        endcase
    endfunction

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .en      ((r_state == ST_IDLE) && !rst),
        .req_a   (a_valid),
        .req_b   (b_valid),
        .update  (w_accept),
        .grant_a (w_grant_a),
        .grant_b (w_grant_b)
    );

    assign a_ready   = w_grant_a;
    assign b_ready   = w_grant_b;
    assign w_accept  = w_grant_a | w_grant_b;
    assign w_cmd_in  = w_grant_b ? b_cmd  : a_cmd;
    assign w_chan_in = w_grant_b ? b_chan : a_chan;
    assign w_data_in = w_grant_b ? b_data : a_data;

    // Pin decode looks at the command taking effect next cycle, including one
    // being accepted right now, so PRE_n/CLR_n drop on the edge after accept.
    assign w_cmd_sel  = w_accept ? w_cmd_in  : r_cmd;
    assign w_chan_sel = w_accept ? w_chan_in : r_chan;
    assign w_chan_oh  = w_chan_sel ? 2'b10 : 2'b01;
    assign w_cnt_done = (r_cnt == '0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (w_cmd_in)
                        CMD_LOAD:   w_next = ST_SETUP;
                        CMD_PRESET,
                        CMD_CLEAR:  w_next = ST_PULSE;
                        default:    w_next = ST_SETTLE;
                    endcase
                end
            end
            ST_SETUP:  if (w_cnt_done) w_next = ST_HIGH;
            ST_HIGH:   if (w_cnt_done) w_next = ST_LOW;
            ST_LOW:    if (w_cnt_done) w_next = ST_SETTLE;
            ST_PULSE:  if (w_cnt_done) w_next = ST_SETTLE;
            ST_SETTLE: if (w_cnt_done) w_next = ST_DONE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Self-check: unknown Q, non-complementary outputs, or a wrong Q value.
    assign w_q   = r_chan ? P9 : P5;
    assign w_qb  = r_chan ? P8 : P6;
    assign w_err = ((w_q !== 1'b0) && (w_q !== 1'b1)) ||
                   (w_qb !== ~w_q) ||
                   ((r_cmd != CMD_READ) && (w_q !== expected_q(r_cmd, r_data)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_cmd       <= CMD_LOAD;
            r_chan      <= 1'b0;
            r_data      <= 1'b0;
            r_id        <= REQ_A;
            r_clk       <= 2'b00;
            r_d         <= 2'b00;
            r_pre_n     <= 2'b11;
            r_clr_n     <= 2'b11;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_q     <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_cnt <= phase_init(w_next);
            end else if (!w_cnt_done) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            if (w_accept) begin
                r_cmd  <= w_cmd_in;
                r_chan <= w_chan_in;
                r_data <= w_data_in;
                r_id   <= w_grant_b;
                if (w_cmd_in == CMD_LOAD) begin
                    r_d[w_chan_in] <= w_data_in;
                end
            end

            r_clk   <= (w_next == ST_HIGH) ? w_chan_oh : 2'b00;
            r_pre_n <= ~(((w_next == ST_PULSE) && (w_cmd_sel == CMD_PRESET)) ? w_chan_oh : 2'b00);
            r_clr_n <= ~(((w_next == ST_PULSE) && (w_cmd_sel == CMD_CLEAR))  ? w_chan_oh : 2'b00);

            r_rsp_valid <= (r_state == ST_DONE);
            r_rsp_id    <= (r_state == ST_DONE) ? r_id  : 1'b0;
            r_rsp_q     <= (r_state == ST_DONE) ? w_q   : 1'b0;
            r_rsp_err   <= (r_state == ST_DONE) ? w_err : 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_q     = r_rsp_q;
    assign rsp_err   = r_rsp_err;

    assign P1  = r_clr_n[0];
    assign P2  = r_d[0];
    assign P3  = r_clk[0];
    assign P4  = r_pre_n[0];
    assign P10 = r_pre_n[1];
    assign P11 = r_clk[1];
    assign P12 = r_d[1];
    assign P13 = r_clr_n[1];

`ifdef SN7474_CTRL_STATS_EN
    logic [15:0] r_stat_cmds, r_stat_errs;

    // Counted on the DONE edge so the totals move together with rsp_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_cmds <= '0;
            r_stat_errs <= '0;
        end else if (r_state == ST_DONE) begin
            if (r_stat_cmds != 16'hFFFF) r_stat_cmds <= r_stat_cmds + 16'd1;
            if (w_err && (r_stat_errs != 16'hFFFF)) r_stat_errs <= r_stat_errs + 16'd1;
        end
    end

    assign stat_cmds = r_stat_cmds;
    assign stat_errs = r_stat_errs;
`else
    assign stat_cmds = '0;
    assign stat_errs = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sn7474_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sn7474_ctrl
// Purpose  : Self-checking bench for sn7474_ctrl with a behavioural sn7474.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sn7474_ctrl;
    localparam int T_SETUP = 3, T_HIGH = 6, T_LOW = 3, T_PULSE = 1, T_SETTLE = 1;
    localparam int LAT_LOAD = T_SETUP + T_HIGH + T_LOW + T_SETTLE + 1;
    localparam int LAT_PC   = T_PULSE + T_SETTLE + 1;
    localparam int LAT_RD   = T_SETTLE + 1;
    localparam logic [1:0] C_LOAD = 2'b00, C_PRESET = 2'b01, C_CLEAR = 2'b10, C_READ = 2'b11;
`ifdef SN7474_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic a_valid = 1'b0, a_chan = 1'b0, a_data = 1'b0;
    logic b_valid = 1'b0, b_chan = 1'b0, b_data = 1'b0;
    logic [1:0] a_cmd = 2'b00, b_cmd = 2'b00;
    logic a_ready, b_ready, rsp_valid, rsp_id, rsp_q, rsp_err;
    logic P1, P2, P3, P4, P5, P6, P8, P9, P10, P11, P12, P13;
    logic [15:0] stat_cmds, stat_errs;

    int n_checks = 0, n_pass = 0;

    always #5 clk = ~clk;

    sn7474_ctrl #(.T_SETUP(T_SETUP), .T_HIGH(T_HIGH), .T_LOW(T_LOW),
                  .T_PULSE(T_PULSE), .T_SETTLE(T_SETTLE), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_cmd(a_cmd), .a_chan(a_chan), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_cmd(b_cmd), .b_chan(b_chan), .b_data(b_data),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_err(rsp_err),
        .P1(P1), .P2(P2), .P3(P3), .P4(P4), .P5(P5), .P6(P6), .P8(P8), .P9(P9),
        .P10(P10), .P11(P11), .P12(P12), .P13(P13),
        .stat_cmds(stat_cmds), .stat_errs(stat_errs)
    );

    // Behavioural sn7474; 'fault' pins channel-1 Q (P5) at 0.
    logic q1 = 1'b0, q2 = 1'b0, fault = 1'b0;
    always @(posedge P3 or negedge P1 or negedge P4) begin
        if (!P1) q1 <= 1'b0; else if (!P4) q1 <= 1'b1; else q1 <= P2;
    end
    always @(posedge P11 or negedge P13 or negedge P10) begin
        if (!P13) q2 <= 1'b0; else if (!P10) q2 <= 1'b1; else q2 <= P12;
    end
    assign P5 = fault ? 1'b0 : q1;
    assign P6 = ~q1;
    assign P9 = q2;
    assign P8 = ~q2;

    // Pin activity since the last accept, sampled on the falling edge.
    int rel, p1_low, p4_low, p10_low, p13_low, p3_high, p11_high, p3_first, both_ready;
    always @(negedge clk) begin
        if (!P1) p1_low++;
        if (!P4) p4_low++;
        if (!P10) p10_low++;
        if (!P13) p13_low++;
        if (P3) begin if (p3_high == 0) p3_first = rel; p3_high++; end
        if (P11) p11_high++;
        if (a_ready && b_ready) both_ready++;
        rel++;
    end

    task automatic clr_mon();
        rel = 0; p1_low = 0; p4_low = 0; p10_low = 0; p13_low = 0;
        p3_high = 0; p11_high = 0; p3_first = -1;
    endtask

    // Reference model: true flip-flop contents, D-pin history, stat totals.
    logic [1:0] ref_ff = 2'b00, last_d = 2'b00;
    int exp_cmds = 0, exp_errs = 0;

    task automatic model(input logic [1:0] cmd, input logic chan, input logic data,
                         output logic eq, output logic ee);
        logic tq, oq;
        case (cmd)
            C_LOAD:   tq = data;
            C_PRESET: tq = 1'b1;
            C_CLEAR:  tq = 1'b0;
            default:  tq = ref_ff[chan];
        endcase
        ref_ff[chan] = tq;
        if (cmd == C_LOAD) last_d[chan] = data;
        oq = (fault && chan == 1'b0) ? 1'b0 : tq;
        eq = oq;
        ee = (~tq != ~oq) || (cmd != C_READ && oq != tq);
        exp_cmds++;
        if (ee) exp_errs++;
    endtask

    function automatic int lat_of(input logic [1:0] cmd);
        return (cmd == C_LOAD) ? LAT_LOAD : (cmd == C_READ) ? LAT_RD : LAT_PC;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        exp_cmds = 0; exp_errs = 0; last_d = 2'b00;
    endtask

    // Issues one command and waits (bounded) for its response.
    task automatic run_cmd(input logic req, input logic [1:0] cmd, input logic chan,
                           input logic data, output int lat, output logic id,
                           output logic q, output logic err, output logic ok);
        int guard;
        @(posedge clk); #1;
        if (req) begin b_valid = 1'b1; b_cmd = cmd; b_chan = chan; b_data = data; end
        else     begin a_valid = 1'b1; a_cmd = cmd; a_chan = chan; a_data = data; end
        #1;
        guard = 0;
        while (!(req ? b_ready : a_ready) && guard < 100) begin @(posedge clk); #2; guard++; end
        ok = (guard < 100);
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        clr_mon();
        lat = 0;
        while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        ok = ok && rsp_valid;
        id = rsp_id; q = rsp_q; err = rsp_err;
    endtask

    task automatic test_reset();
        a_valid = 1'b1; b_valid = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        n_checks++; if ({P1, P4, P10, P13} !== 4'b1111) $display("FAIL reset_pre_clr: got %b want 1111", {P1, P4, P10, P13}); else n_pass++;
        n_checks++; if ({P3, P11, P2, P12} !== 4'b0000) $display("FAIL reset_clk_d: got %b want 0000", {P3, P11, P2, P12}); else n_pass++;
        n_checks++; if ({a_ready, b_ready, rsp_valid, rsp_id, rsp_q, rsp_err} !== 6'b0) $display("FAIL reset_ready_rsp: got %b want 000000", {a_ready, b_ready, rsp_valid, rsp_id, rsp_q, rsp_err}); else n_pass++;
        n_checks++; if ({stat_cmds, stat_errs} !== 32'h0) $display("FAIL reset_stats: got %h want 0", {stat_cmds, stat_errs}); else n_pass++;
        a_valid = 1'b0; b_valid = 1'b0; rst = 1'b0;
    endtask

    task automatic test_preset();
        int lat; logic id, q, err, ok, eq, ee;
        model(C_PRESET, 1'b0, 1'b0, eq, ee);
        run_cmd(1'b0, C_PRESET, 1'b0, 1'b0, lat, id, q, err, ok);
        n_checks++; if (!ok || lat != LAT_PC) $display("FAIL preset_latency: got %0d want %0d", lat, LAT_PC); else n_pass++;
        n_checks++; if ({id, q, err} !== {1'b0, eq, ee}) $display("FAIL preset_rsp: got id/q/err %b want %b", {id, q, err}, {1'b0, eq, ee}); else n_pass++;
        n_checks++; if (p4_low != T_PULSE || p1_low + p10_low + p13_low != 0) $display("FAIL preset_pins: got p4_low %0d others %0d want %0d 0", p4_low, p1_low + p10_low + p13_low, T_PULSE); else n_pass++;
    endtask

    task automatic test_clear();
        int lat; logic id, q, err, ok, eq, ee;
        model(C_CLEAR, 1'b1, 1'b0, eq, ee);
        run_cmd(1'b0, C_CLEAR, 1'b1, 1'b0, lat, id, q, err, ok);
        n_checks++; if (!ok || lat != LAT_PC) $display("FAIL clear_latency: got %0d want %0d", lat, LAT_PC); else n_pass++;
        n_checks++; if ({id, q, err, P9, P8} !== {1'b0, eq, ee, 1'b0, 1'b1}) $display("FAIL clear_rsp: got id/q/err/P9/P8 %b want %b", {id, q, err, P9, P8}, {1'b0, eq, ee, 2'b01}); else n_pass++;
        n_checks++; if (p13_low != T_PULSE || p1_low + p4_low + p10_low != 0) $display("FAIL clear_pins: got p13_low %0d others %0d want %0d 0", p13_low, p1_low + p4_low + p10_low, T_PULSE); else n_pass++;
    endtask

    task automatic test_load();
        int lat; logic id, q, err, ok, eq, ee;
        for (int k = 0; k < 2; k++) begin
            logic d;
            d = (k == 0);
            model(C_LOAD, 1'b0, d, eq, ee);
            run_cmd(1'b1, C_LOAD, 1'b0, d, lat, id, q, err, ok);
            n_checks++; if (!ok || lat != LAT_LOAD) $display("FAIL load_latency: got %0d want %0d", lat, LAT_LOAD); else n_pass++;
            n_checks++; if ({id, q, err, P2} !== {1'b1, eq, ee, d}) $display("FAIL load_rsp: got id/q/err/P2 %b want %b", {id, q, err, P2}, {1'b1, eq, ee, d}); else n_pass++;
            n_checks++; if (p3_high != T_HIGH || p3_first != T_SETUP || p11_high != 0) $display("FAIL load_clk: got high %0d first %0d p11 %0d want %0d %0d 0", p3_high, p3_first, p11_high, T_HIGH, T_SETUP); else n_pass++;
        end
    endtask

    task automatic test_contention();
        logic last; logic exp_g, got, eq, ee;
        logic exp_id[$]; logic exp_q[$];
        int grants, rsps, guard;
        do_reset();
        last = 1'b1;
        both_ready = 0;
        for (int r = 0; r < 2; r++) begin
            @(posedge clk); #1;
            a_valid = 1'b1; a_cmd = C_READ; a_chan = 1'b0;
            b_valid = 1'b1; b_cmd = C_READ; b_chan = 1'b1;
            #1;
            grants = 0; rsps = 0; guard = 0;
            while ((grants < 2 || rsps < 2) && guard < 80) begin
                if (rsp_valid && exp_id.size() > 0) begin
                    logic wid, wq;
                    wid = exp_id.pop_front(); wq = exp_q.pop_front();
                    n_checks++; if ({rsp_id, rsp_q, rsp_err} !== {wid, wq, 1'b0}) $display("FAIL contention_rsp: got id/q/err %b want %b", {rsp_id, rsp_q, rsp_err}, {wid, wq, 1'b0}); else n_pass++;
                    rsps++;
                end
                if (a_ready || b_ready) begin
                    got = b_ready;
                    exp_g = (a_valid && b_valid) ? ~last : b_valid;
                    n_checks++; if (got !== exp_g) $display("FAIL contention_grant: got %0d want %0d", got, exp_g); else n_pass++;
                    last = got;
                    model(C_READ, got, 1'b0, eq, ee);
                    exp_id.push_back(got); exp_q.push_back(eq);
                    grants++;
                    @(posedge clk); #1;
                    if (got) b_valid = 1'b0; else a_valid = 1'b0;
                    #1;
                end else begin
                    @(posedge clk); #2;
                end
                guard++;
            end
            n_checks++; if (grants != 2 || rsps != 2) $display("FAIL contention_timeout: got grants %0d rsps %0d want 2 2", grants, rsps); else n_pass++;
        end
        n_checks++; if (both_ready != 0) $display("FAIL contention_both_ready: got %0d want 0", both_ready); else n_pass++;
    endtask

    task automatic test_fault();
        int lat; logic id, q, err, ok, eq, ee;
        fault = 1'b1;
        model(C_LOAD, 1'b0, 1'b1, eq, ee);
        run_cmd(1'b0, C_LOAD, 1'b0, 1'b1, lat, id, q, err, ok);
        n_checks++; if (!ok || {q, err} !== {eq, ee} || ee !== 1'b1) $display("FAIL fault_rsp: got q/err %b want %b", {q, err}, {eq, ee}); else n_pass++;
        n_checks++; if (stat_cmds !== (STATS ? 16'(exp_cmds) : 16'h0) || stat_errs !== (STATS ? 16'(exp_errs) : 16'h0)) $display("FAIL fault_stats: got %0d %0d want %0d %0d", stat_cmds, stat_errs, STATS ? exp_cmds : 0, STATS ? exp_errs : 0); else n_pass++;
        fault = 1'b0;
    endtask

    task automatic test_reset_mid();
        int guard, spurious; logic d, eq, ee;
        d = 1'(~ref_ff[0]);
        @(posedge clk); #1;
        a_valid = 1'b1; a_cmd = C_LOAD; a_chan = 1'b0; a_data = d;
        #1;
        guard = 0;
        while (!a_ready && guard < 50) begin @(posedge clk); #2; guard++; end
        @(posedge clk); #1; a_valid = 1'b0;
        while (!P3 && guard < 80) begin @(posedge clk); #1; guard++; end
        n_checks++; if (P3 !== 1'b1) $display("FAIL reset_mid_reach_high: got P3 %b want 1", P3); else n_pass++;
        ref_ff[0] = d;
        rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
        @(posedge clk); #2;
        n_checks++; if ({P3, rsp_valid, a_ready, b_ready} !== 4'b0000) $display("FAIL reset_mid_pins: got P3/rsp/ar/br %b want 0000", {P3, rsp_valid, a_ready, b_ready}); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0; exp_cmds = 0; exp_errs = 0; last_d = 2'b00;
        a_cmd = C_READ; b_cmd = C_READ; b_chan = 1'b1;
        #1;
        n_checks++; if ({a_ready, b_ready} !== 2'b10) $display("FAIL reset_mid_grant: got a/b ready %b want 10", {a_ready, b_ready}); else n_pass++;
        model(C_READ, 1'b0, 1'b0, eq, ee);
        @(posedge clk); #1; a_valid = 1'b0; b_valid = 1'b0;
        spurious = 0; guard = 0;
        while (!rsp_valid && guard < 20) begin @(posedge clk); #1; guard++; end
        n_checks++; if (!rsp_valid || {rsp_id, rsp_q, rsp_err} !== {1'b0, eq, ee}) $display("FAIL reset_mid_read: got v/id/q/err %b want %b", {rsp_valid, rsp_id, rsp_q, rsp_err}, {1'b1, 1'b0, eq, ee}); else n_pass++;
        repeat (20) begin @(posedge clk); #1; if (rsp_valid) spurious++; end
        n_checks++; if (spurious != 0) $display("FAIL reset_mid_spurious_rsp: got %0d want 0", spurious); else n_pass++;
    endtask

    task automatic test_random();
        int lat; logic id, q, err, ok, eq, ee, req, chan, data; logic [1:0] cmd;
        for (int i = 0; i < 24; i++) begin
            req = 1'($urandom_range(1)); cmd = 2'($urandom_range(3));
            chan = 1'($urandom_range(1)); data = 1'($urandom_range(1));
            model(cmd, chan, data, eq, ee);
            run_cmd(req, cmd, chan, data, lat, id, q, err, ok);
            n_checks++; if (!ok || lat != lat_of(cmd) || {id, q, err} !== {req, eq, ee}) $display("FAIL random_%0d cmd %0d: got lat %0d id/q/err %b want lat %0d %b", i, cmd, lat, {id, q, err}, lat_of(cmd), {req, eq, ee}); else n_pass++;
            n_checks++; if ({P12, P2} !== last_d) $display("FAIL random_%0d_dpins: got %b want %b", i, {P12, P2}, last_d); else n_pass++;
        end
        n_checks++; if (stat_cmds !== (STATS ? 16'(exp_cmds) : 16'h0) || stat_errs !== (STATS ? 16'(exp_errs) : 16'h0)) $display("FAIL random_stats: got %0d %0d want %0d %0d", stat_cmds, stat_errs, STATS ? exp_cmds : 0, STATS ? exp_errs : 0); else n_pass++;
    endtask

    initial begin
        clr_mon();
        both_ready = 0;
        test_reset();
        test_preset();
        test_clear();
        test_load();
        test_contention();
        test_fault();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/sn7474_ctrl.md
Name: sn7474_ctrl

Overview:
- Synchronous sequencer that drives the pin-level inputs of one sn7474 dual D flip-flop and reads back its outputs.
- Two requesters (A, B) issue commands (LOAD, PRESET, CLEAR, READ) to either flip-flop channel; a round-robin arbiter picks one command at a time.
- FSM generates clock/preset/clear pulses with programmable phase widths, samples Q/Qbar, and returns a response with a self-check error flag.
- Sits between test/control logic and an sn7474 instance; its outputs connect directly to the chip's pins.

Parameters:
- T_SETUP, 3, cycles CLK held low with D driven before the rising edge (>=1)
- T_HIGH, 6, cycles CLK high (>=1)
- T_LOW, 3, cycles CLK low after the falling edge (>=1)
- T_PULSE, 1, cycles PRE/CLR held low for async commands (>=1)
- T_SETTLE, 1, idle cycles before sampling Q/Qbar (>=1)
- CNT_W, 4, phase-counter width; must hold max(T_*)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- a_valid / b_valid  in  1  requester command valid
- a_ready / b_ready  out  1  command accepted this cycle when valid&ready
- a_cmd / b_cmd  in  2  00 LOAD, 01 PRESET, 10 CLEAR, 11 READ
- a_chan / b_chan  in  1  0 = FF1 (P1-P6), 1 = FF2 (P8-P13)
- a_data / b_data  in  1  D value for LOAD
- rsp_valid  out  1  one-cycle response strobe
- rsp_id  out  1  0 = A, 1 = B
- rsp_q  out  1  sampled Q
- rsp_err  out  1  self-check failure
- P1 out 1CLR_n; P2 out 1D; P3 out 1CLK; P4 out 1PRE_n
- P5 in 1Q; P6 in 1Qbar; P8 in 2Qbar; P9 in 2Q
- P10 out 2PRE_n; P11 out 2CLK; P12 out 2D; P13 out 2CLR_n
- stat_cmds  out  16  commands completed
- stat_errs  out  16  responses with rsp_err=1

Behaviour:
- Reset: FSM enters IDLE.
  - P1, P4, P10, P13 = 1; P3, P11 = 0; P2, P12 = 0.
  - rsp_* = 0; a_ready, b_ready = 0 during reset.
  - The arbiter's last-grant register is set to B, so A wins the first tie.
- States: IDLE, SETUP, HIGH, LOW, PULSE, SETTLE, DONE.
- Arbitration:
  - Evaluated only in IDLE.
  - One valid requester: it is granted.
  - Both valid: grant the one not granted last.
  - a_ready = IDLE & grant_a (combinational); likewise b_ready.
  - Never both high. Acceptance latches cmd, chan and data and updates last-grant.
- Transitions after acceptance:
  - LOAD: the selected D pin takes data on the cycle after accept. Then SETUP (T_SETUP cycles, CLK 0) -> HIGH (T_HIGH, CLK 1) -> LOW (T_LOW, CLK 0) -> SETTLE.
  - PRESET/CLEAR: PULSE (T_PULSE cycles, selected PRE_n/CLR_n = 0) -> SETTLE.
  - READ: go directly to SETTLE.
- SETTLE (T_SETTLE cycles) -> DONE. In DONE (one cycle) Q and Qbar of the selected channel are sampled and rsp_valid = 1.
  - rsp_id = granted requester; rsp_q = sampled Q.
  - DONE -> IDLE.
- Latency, accept edge to rsp_valid, in cycles:
  - LOAD: T_SETUP+T_HIGH+T_LOW+T_SETTLE+1 (14 at defaults).
  - PRESET/CLEAR: T_PULSE+T_SETTLE+1 (3).
  - READ: T_SETTLE+1 (2).
- Ready is low outside IDLE. Minimum spacing between accepts is latency+1.
- The unselected channel's pins hold idle values throughout. D pins hold their last LOAD value between commands.
- Self-check: rsp_err = 1 if Q !== expected, or Qbar !== ~Q (X/Z counts as an error).
  - Expected Q: LOAD = data, PRESET = 1, CLEAR = 0.
  - READ checks only complementarity.
- Reset mid-command: pins return to idle on the next edge and the command is dropped with no response.

Optional Feature:
- Macro: SN7474_CTRL_STATS_EN.
- Defined: stat_cmds increments on every rsp_valid and stat_errs on every rsp_valid & rsp_err. Both saturate at 16'hFFFF and clear on rst.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package sn7474_ctrl_pkg holds:
  - command encodings (CMD_LOAD, CMD_PRESET, CMD_CLEAR, CMD_READ);
  - FSM state encodings;
  - requester-id constants.
- Sub-module rr_arb2: two-input round-robin arbiter with a last-grant register and a grant-update strobe.
- FSM, counters and pin drive stay in the top level.

Test Plan:
- After rst: P1=P4=P10=P13=1, P3=P11=0, P2=P12=0. A issues PRESET ch0 -> P4 low one cycle; rsp_valid at accept+3 with rsp_q=1, rsp_err=0, rsp_id=0.
- A issues CLEAR ch1 -> P13 low one cycle; rsp_q=0 (P9=0, P8=1) at accept+3, rsp_err=0.
- B issues LOAD ch0 with data=1 -> P2=1; P3 low for 3 cycles, high for 6, low for 3; rsp at accept+14 with rsp_q=1, rsp_id=1. Repeat with data=0 -> rsp_q=0.
- A and B valid in the same IDLE cycle twice in a row -> first grant A, then B; ready is never high for both at once; the loser stays pending until granted.
- Substitute a faulty model holding P5=0 and issue LOAD data=1 -> rsp_err=1; with SN7474_CTRL_STATS_EN defined, stat_errs=1 and stat_cmds increments.
- Assert rst during HIGH of a LOAD -> P3=0 on the next edge, no rsp_valid, and A is granted first afterwards.
